// File: rtl/div_sequencer_if.sv
// div_sequencer_if
// Handshake/data bundle between the execute stage and the divider.
//   master : EXE side    - drives div_en/div_sign/div_src1/div_src2/div_go/flush,
//                          receives div_complete/div_busy/div_quotient/div_remainder
//   slave  : divider side - the reverse directions
interface div_sequencer_if #(
    parameter int DATA_W = 32
);
    logic              div_en;
    logic              div_sign;
    logic [DATA_W-1:0] div_src1;
    logic [DATA_W-1:0] div_src2;
    logic              div_go;
    logic              flush;
    logic              div_complete;
    logic              div_busy;
    logic [DATA_W-1:0] div_quotient;
    logic [DATA_W-1:0] div_remainder;

    modport master (
        output div_en, div_sign, div_src1, div_src2, div_go, flush,
        input  div_complete, div_busy, div_quotient, div_remainder
    );

    modport slave (
        input  div_en, div_sign, div_src1, div_src2, div_go, flush,
        output div_complete, div_busy, div_quotient, div_remainder
    );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer
// Multi-cycle radix-2 restoring divider controller for the execute stage.
// Accepts a request in IDLE, runs DATA_W iterations, sign-corrects in FIX and
// holds the result with div_complete in DONE until EXE retires (div_go).
// A flush aborts from any state.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset (also clears the result outputs)
//   bus   : div_sequencer_if slave modport (request, operands, go, flush,
//           complete, busy, quotient, remainder)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for div_en; operands latched on acceptance
// ITER  | one restoring iteration per cycle, DATA_W cycles in total
// FIX   | sign correction / divide-by-zero override, result registered
// DONE  | div_complete held until div_go
module div_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic            clk,
    input  logic            reset,
    div_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sa;
    logic              r_neg_q;
    logic              r_dz;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_dvd;
    logic [DATA_W-1:0] r_dvs;
    logic [DATA_W-1:0] r_rem;
    logic              r_complete;
    logic              r_busy;
    logic [DATA_W-1:0] r_quot;
    logic [DATA_W-1:0] r_rem_out;

    logic              w_neg1;
    logic              w_neg2;
    logic [DATA_W-1:0] w_abs1;
    logic [DATA_W-1:0] w_abs2;
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W:0]   w_trial;
    logic              w_q_bit;
    logic              w_cnt_last;
    logic [DATA_W-1:0] w_quot_fix;
    logic [DATA_W-1:0] w_rem_fix;

    // Sign bits only count for signed requests; magnitudes feed the unsigned core.
    assign w_neg1 = bus.div_sign & bus.div_src1[DATA_W-1];
    assign w_neg2 = bus.div_sign & bus.div_src2[DATA_W-1];
    assign w_abs1 = w_neg1 ? (~bus.div_src1 + 1'b1) : bus.div_src1;
    assign w_abs2 = w_neg2 ? (~bus.div_src2 + 1'b1) : bus.div_src2;

    // One extra bit on the trial subtraction so its MSB is the borrow.
    assign w_rem_sh   = {r_rem, r_dvd[DATA_W-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_dvs};
    assign w_q_bit    = ~w_trial[DATA_W];
    assign w_cnt_last = (r_cnt == CNT_W'(DATA_W - 1));

    // The dividend register holds the quotient once all bits are shifted in.
    assign w_quot_fix = r_neg_q ? (~r_dvd + 1'b1) : r_dvd;
    assign w_rem_fix  = r_sa    ? (~r_rem + 1'b1) : r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sa       <= 1'b0;
            r_neg_q    <= 1'b0;
            r_dz       <= 1'b0;
            r_src1     <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_rem      <= '0;
            r_complete <= 1'b0;
            r_busy     <= 1'b0;
            r_quot     <= '0;
            r_rem_out  <= '0;
        end else if (bus.flush) begin
            r_state    <= S_IDLE;
            r_complete <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.div_en) begin
                        r_sa    <= w_neg1;
                        r_neg_q <= w_neg1 ^ w_neg2;
                        r_dz    <= (bus.div_src2 == '0);
                        r_src1  <= bus.div_src1;
                        r_dvd   <= w_abs1;
                        r_dvs   <= w_abs2;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    // A failed trial leaves the shifted value below the divisor,
                    // so it always fits back into DATA_W bits.
                    r_rem <= w_q_bit ? w_trial[DATA_W-1:0] : w_rem_sh[DATA_W-1:0];
                    r_dvd <= {r_dvd[DATA_W-2:0], w_q_bit};
                    r_cnt <= r_cnt + 1'b1;
                    if (w_cnt_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_quot     <= r_dz ? '1     : w_quot_fix;
                    r_rem_out  <= r_dz ? r_src1 : w_rem_fix;
                    r_complete <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (bus.div_go) begin
                        r_complete <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.div_complete  = r_complete;
    assign bus.div_busy      = r_busy;
    assign bus.div_quotient  = r_quot;
    assign bus.div_remainder = r_rem_out;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    div_sequencer_if #(.DATA_W(32)) bus ();

    div_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept in the current cycle, scramble operands afterwards, expect the
    // result 34 cycles later. Leaves the block in DONE with div_en held.
    task automatic run_div(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                           input logic sgn, input logic [31:0] eq, input logic [31:0] er);
        int n;
        bus.div_en   = 1'b1;
        bus.div_sign = sgn;
        bus.div_src1 = s1;
        bus.div_src2 = s2;
        chk({tag, "_idle_busy"}, {31'b0, bus.div_busy}, 32'd0);
        for (n = 1; n <= 60; n++) begin
            tick();
            bus.div_src1 = ~s1;
            bus.div_src2 = s2 ^ 32'h0000_0005;
            bus.div_sign = ~sgn;
            if (bus.div_complete) break;
        end
        chk({tag, "_latency"}, n, 32'd34);
        chk({tag, "_quot"}, bus.div_quotient, eq);
        chk({tag, "_rem"}, bus.div_remainder, er);
        chk({tag, "_busy"}, {31'b0, bus.div_busy}, 32'd1);
    endtask

    task automatic retire(input string tag);
        bus.div_go = 1'b1;
        tick();
        bus.div_go = 1'b0;
        bus.div_en = 1'b0;
        chk({tag, "_ret_complete"}, {31'b0, bus.div_complete}, 32'd0);
        chk({tag, "_ret_busy"}, {31'b0, bus.div_busy}, 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        bus.div_en   = 1'b0;
        bus.div_sign = 1'b0;
        bus.div_src1 = '0;
        bus.div_src2 = '0;
        bus.div_go   = 1'b0;
        bus.flush    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        chk("rst_complete", {31'b0, bus.div_complete}, 32'd0);
        chk("rst_busy", {31'b0, bus.div_busy}, 32'd0);
        chk("rst_quot", bus.div_quotient, 32'd0);
        chk("rst_rem", bus.div_remainder, 32'd0);

        run_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        retire("u100_7");

        run_div("s-7_2", 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        retire("s-7_2");

        run_div("s7_-2", 32'h7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h1);
        retire("s7_-2");

        run_div("s_dz", 32'h8000_0000, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
        retire("s_dz");

        run_div("u_dz", 32'd1234, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'd1234);
        retire("u_dz");

        run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0);
        retire("s_ovf");

        // Abort at iteration 10, then 5 / 5 accepted the very next cycle.
        bus.div_en   = 1'b1;
        bus.div_sign = 1'b0;
        bus.div_src1 = 32'd1000;
        bus.div_src2 = 32'd3;
        repeat (10) tick();
        chk("flush_busy_before", {31'b0, bus.div_busy}, 32'd1);
        bus.flush  = 1'b1;
        bus.div_en = 1'b0;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy_after", {31'b0, bus.div_busy}, 32'd0);
        chk("flush_complete_after", {31'b0, bus.div_complete}, 32'd0);
        run_div("u5_5", 32'd5, 32'd5, 1'b0, 32'd1, 32'd0);
        retire("u5_5");

        // MS stall: hold DONE for 5 cycles with operands wiggling.
        run_div("u1000_3", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.div_src1 = 32'hDEAD_0000 + i;
            bus.div_src2 = 32'h0000_0011 + i;
            tick();
            chk("hold_complete", {31'b0, bus.div_complete}, 32'd1);
            chk("hold_quot", bus.div_quotient, 32'd333);
            chk("hold_rem", bus.div_remainder, 32'd1);
        end
        retire("u1000_3");

        // Back-to-back: accepted in the cycle right after div_go.
        run_div("uffff_10", 32'hFFFF_FFFF, 32'h10, 1'b0, 32'h0FFF_FFFF, 32'hF);

        // flush and div_go together in DONE.
        bus.div_go = 1'b1;
        bus.flush  = 1'b1;
        tick();
        bus.div_go = 1'b0;
        chk("flush_go_busy", {31'b0, bus.div_busy}, 32'd0);
        chk("flush_go_complete", {31'b0, bus.div_complete}, 32'd0);

        // flush with div_en in IDLE: no acceptance.
        bus.div_en   = 1'b1;
        bus.div_sign = 1'b0;
        bus.div_src1 = 32'd9;
        bus.div_src2 = 32'd2;
        tick();
        chk("flush_idle_busy", {31'b0, bus.div_busy}, 32'd0);
        bus.flush = 1'b0;
        tick();
        chk("accept_after_flush_busy", {31'b0, bus.div_busy}, 32'd1);

        // Reset mid-operation clears state and outputs.
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        bus.div_en = 1'b0;
        chk("midrst_busy", {31'b0, bus.div_busy}, 32'd0);
        chk("midrst_complete", {31'b0, bus.div_complete}, 32'd0);
        chk("midrst_quot", bus.div_quotient, 32'd0);
        chk("midrst_rem", bus.div_remainder, 32'd0);

        run_div("u_after_rst", 32'd50, 32'd6, 1'b0, 32'd8, 32'd2);
        retire("u_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle integer divider controller for the execute stage. It accepts a divide request from EXE, runs a fixed-latency radix-2 restoring iteration, and applies sign correction. It holds quotient and remainder with `div_complete` until EXE retires the instruction. It aborts cleanly on an exception or ertn flush. It sits beside `exe_stage` and drives the `div_complete` input that gates `es_ready_go`.

## Interface
Parameters:
- `DATA_W`, 32: operand and result width.
- `CNT_W`, 6: iteration counter width; must hold `DATA_W`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `div_en`  in  1  EXE holds a valid div/mod instruction (`es_div_enable`); level, held until retire.
- `div_sign`  in  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu).
- `div_src1`  in  DATA_W  dividend (`es_rj_value`).
- `div_src2`  in  DATA_W  divisor (`es_rkd_value`).
- `div_go`  in  1  EXE instruction leaves EXE this cycle (`es_to_ms_valid && ms_allowin`).
- `flush`  in  1  `excp_flush | ertn_flush`.
- `div_complete`  out  1  results valid; EXE may proceed.
- `div_busy`  out  1  state is not IDLE.
- `div_quotient`  out  DATA_W  quotient.
- `div_remainder`  out  DATA_W  remainder.

## Operation
- States: IDLE, ITER, FIX, DONE. Counter `cnt[CNT_W-1:0]`.
- **IDLE**
  - If `div_en && !flush`, latch operands, `div_sign`, `sa = sign && src1[31]`, `sb = sign && src2[31]`, and `dz = (src2 == 0)`.
  - Load magnitudes `|src1|` and `|src2|`. Absolute value applies only when the sign bit counts.
  - Clear the partial remainder and set `cnt = 0`. Go to ITER.
- **ITER**
  - Each cycle: shift `{rem, dividend}` left by 1, then compute trial = `rem - divisor` in 33 bits.
  - If non-negative, `rem = trial` and the shifted-in quotient bit is 1; otherwise the bit is 0.
  - Increment `cnt`. After the iteration with `cnt == DATA_W-1`, go to FIX. This is exactly `DATA_W` iterations.
- **FIX**
  - Quotient = `sa^sb ? -q : q`. Remainder = `sa ? -r : r`. Register both outputs. Go to DONE.
  - Divide by zero (`dz`): quotient = all ones, remainder = original `div_src1`, for signed and unsigned alike. Latency is unchanged.
  - Overflow case `0x80000000 / 0xFFFFFFFF` signed gives quotient 0x80000000 and remainder 0. This falls out of the algorithm with no special case.
- **DONE**
  - `div_complete = 1`. Outputs stay stable.
  - On `div_go`, go to IDLE. A new request is accepted no earlier than the next cycle.
  - Without `div_go`, stay in DONE regardless of `div_en`.
- **flush** (any state): go to IDLE next cycle and drop `div_complete`. Flush has priority over `div_go` and over acceptance in IDLE.
- Operand changes after acceptance are ignored because operands are latched.
- `div_en` dropping while in ITER or FIX without a flush is illegal; the block continues to DONE.

## Timing
- Reset values: state = IDLE, `cnt = 0`, `div_complete = 0`, `div_busy = 0`, `div_quotient = 0`, `div_remainder = 0`.
- Accept in cycle T (IDLE, `div_en = 1`). ITER runs in cycles T+1..T+32. FIX is in T+33. `div_complete = 1` from T+34.
- EXE therefore stalls for 34 cycles per divide, and `div_go` can first be 1 in T+34.
- `div_complete` is registered, with no combinational path from `div_en`.
- `div_busy` is 1 from T+1 until the cycle after `div_go` or `flush`.
- Back-to-back divides: `div_go` in cycle D returns to IDLE in D+1, and the next instruction is accepted in D+1.
- Reset asserted mid-operation behaves identically to flush and also clears the outputs.

## Test plan
- Unsigned 100 / 7: `div_en` held, `div_sign = 0` → `div_complete` rises exactly 34 cycles after accept; quotient 14, remainder 2.
- Signed −7 / 2 (0xFFFFFFF9, 0x2) → quotient 0xFFFFFFFD (−3), remainder 0xFFFFFFFF (−1). Also 7 / −2 → quotient −3, remainder 1.
- Divide by zero, signed 0x80000000 / 0 → quotient 0xFFFFFFFF, remainder 0x80000000, with 34-cycle latency. Separately, 0x80000000 / 0xFFFFFFFF signed → quotient 0x80000000, remainder 0.
- Flush at iteration 10, then a new request 5 / 5 next cycle → no `div_complete` for the aborted op; new result quotient 1, remainder 0 after 34 cycles.
- Hold in DONE for 5 cycles with `div_go = 0` (ms stall) → outputs and `div_complete` stable. `div_go` then gives IDLE next cycle, and a back-to-back 0xFFFFFFFF / 0x10 unsigned → quotient 0x0FFFFFFF, remainder 0xF.
- Flush and `div_go` together in DONE, and flush with `div_en` in IDLE → IDLE next cycle, no acceptance, `div_busy = 0`.
